// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared bus definitions for the two-master Wishbone arbiter
package wb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        WBARB_IDLE = 2'd0,
        WBARB_GNT0 = 2'd1,
        WBARB_GNT1 = 2'd2
    } wbarb_state_t;

    localparam logic WBARB_M0 = 1'b0;
    localparam logic WBARB_M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - clear/increment/saturate bus-cycle timeout counter
module wb_arb_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic CLK_I,
    input  logic RST_N_I,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Holding at LIMIT keeps hit asserted instead of wrapping back to zero.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - shares one Wishbone slave port between data (M0) and fetch (M1) masters
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 16
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    input  logic [3:0]  M0_SEL_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    input  logic [3:0]  M1_SEL_I,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    output logic [31:0] M0_DAT_O,
    output logic [31:0] M1_DAT_O,
    output logic        M0_ACK_O,
    output logic        M1_ACK_O,
    output logic        M0_ERR_O,
    output logic        M1_ERR_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    output logic [1:0]  GNT_O
);

    wbarb_state_t state, state_nxt;
    logic         last_grant;
    logic         granted;
    logic         to_hit;
    logic         to_fire;

    assign granted = (state != WBARB_IDLE);
    assign to_fire = granted && to_hit && !ACK_I;

    // Counter sits at zero throughout IDLE, so every grant starts from a clean count.
    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .CLK_I   (CLK_I),
        .RST_N_I (RST_N_I),
        .clr     (!granted),
        .inc     (granted && !ACK_I),
        .hit     (to_hit)
    );

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state      <= WBARB_IDLE;
            last_grant <= WBARB_M1;
        end else begin
            state <= state_nxt;
            if (state == WBARB_IDLE && state_nxt == WBARB_GNT0) last_grant <= WBARB_M0;
            if (state == WBARB_IDLE && state_nxt == WBARB_GNT1) last_grant <= WBARB_M1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WBARB_IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    if (ROUND_ROBIN && (last_grant == WBARB_M0)) state_nxt = WBARB_GNT1;
                    else                                          state_nxt = WBARB_GNT0;
                end else if (M0_CYC_I) begin
                    state_nxt = WBARB_GNT0;
                end else if (M1_CYC_I) begin
                    state_nxt = WBARB_GNT1;
                end
            end
            WBARB_GNT0: if (ACK_I || !M0_CYC_I || to_fire) state_nxt = WBARB_IDLE;
            WBARB_GNT1: if (ACK_I || !M1_CYC_I || to_fire) state_nxt = WBARB_IDLE;
            default:    state_nxt = WBARB_IDLE;
        endcase
    end

    assign M0_DAT_O = DAT_I;
    assign M1_DAT_O = DAT_I;

    // A timed-out cycle drops CYC/STB in the same cycle the owner sees ERR.
    always_comb begin
        ADR_O    = '0;
        DAT_O    = '0;
        SEL_O    = '0;
        CYC_O    = 1'b0;
        STB_O    = 1'b0;
        WE_O     = 1'b0;
        M0_ACK_O = 1'b0;
        M1_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ERR_O = 1'b0;
        GNT_O    = 2'b00;
        case (state)
            WBARB_GNT0: begin
                ADR_O    = M0_ADR_I;
                DAT_O    = M0_DAT_I;
                SEL_O    = M0_SEL_I;
                WE_O     = M0_WE_I;
                CYC_O    = M0_CYC_I && !to_fire;
                STB_O    = M0_CYC_I && M0_STB_I && !to_fire;
                M0_ACK_O = ACK_I;
                M0_ERR_O = to_fire;
                GNT_O    = 2'b01;
            end
            WBARB_GNT1: begin
                ADR_O    = M1_ADR_I;
                DAT_O    = M1_DAT_I;
                SEL_O    = M1_SEL_I;
                WE_O     = M1_WE_I;
                CYC_O    = M1_CYC_I && !to_fire;
                STB_O    = M1_CYC_I && M1_STB_I && !to_fire;
                M1_ACK_O = ACK_I;
                M1_ERR_O = to_fire;
                GNT_O    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, dat_i;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, ack_i;

    logic [31:0] r_m0_dat, r_m1_dat, r_adr, r_dat;
    logic [3:0]  r_sel;
    logic        r_m0_ack, r_m1_ack, r_m0_err, r_m1_err, r_cyc, r_stb, r_we;
    logic [1:0]  r_gnt;

    logic [31:0] f_m0_dat, f_m1_dat, f_adr, f_dat;
    logic [3:0]  f_sel;
    logic        f_m0_ack, f_m1_ack, f_m0_err, f_m1_err, f_cyc, f_stb, f_we;
    logic [1:0]  f_gnt;

    int checks   = 0;
    int failures = 0;

    wb_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(8), .TO_W(16)) dut_rr (
        .CLK_I(clk), .RST_N_I(rst_n),
        .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat), .M0_SEL_I(m0_sel),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we),
        .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat), .M1_SEL_I(m1_sel),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we),
        .M0_DAT_O(r_m0_dat), .M1_DAT_O(r_m1_dat),
        .M0_ACK_O(r_m0_ack), .M1_ACK_O(r_m1_ack),
        .M0_ERR_O(r_m0_err), .M1_ERR_O(r_m1_err),
        .ADR_O(r_adr), .DAT_O(r_dat), .SEL_O(r_sel),
        .CYC_O(r_cyc), .STB_O(r_stb), .WE_O(r_we),
        .DAT_I(dat_i), .ACK_I(ack_i), .GNT_O(r_gnt)
    );

    wb_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(8), .TO_W(16)) dut_fp (
        .CLK_I(clk), .RST_N_I(rst_n),
        .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat), .M0_SEL_I(m0_sel),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we),
        .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat), .M1_SEL_I(m1_sel),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we),
        .M0_DAT_O(f_m0_dat), .M1_DAT_O(f_m1_dat),
        .M0_ACK_O(f_m0_ack), .M1_ACK_O(f_m1_ack),
        .M0_ERR_O(f_m0_err), .M1_ERR_O(f_m1_err),
        .ADR_O(f_adr), .DAT_O(f_dat), .SEL_O(f_sel),
        .CYC_O(f_cyc), .STB_O(f_stb), .WE_O(f_we),
        .DAT_I(dat_i), .ACK_I(ack_i), .GNT_O(f_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        dat_i  = '0; ack_i  = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        #3;
        chk("reset_gnt", r_gnt, 2'b00);
        chk("reset_cyc", r_cyc, 1'b0);
        chk("reset_stb", r_stb, 1'b0);
        chk("reset_acks", {r_m0_ack, r_m1_ack, r_m0_err, r_m1_err}, 4'b0000);
        tick();
        rst_n = 1;
        tick();

        // Single read from M0, slave acks in the third granted cycle.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF; m0_we = 0;
        #1;
        chk("rd_latency_gnt", r_gnt, 2'b00);
        chk("rd_latency_cyc", r_cyc, 1'b0);
        tick();
        #1;
        chk("rd_gnt", r_gnt, 2'b01);
        chk("rd_cyc", r_cyc, 1'b1);
        chk("rd_stb", r_stb, 1'b1);
        chk("rd_adr", r_adr, 32'h100);
        chk("rd_sel", r_sel, 4'hF);
        chk("rd_ack_c1", r_m0_ack, 1'b0);
        tick();
        #1;
        chk("rd_ack_c2", r_m0_ack, 1'b0);
        tick();
        ack_i = 1; dat_i = 32'hCAFEF00D;
        #1;
        chk("rd_ack", r_m0_ack, 1'b1);
        chk("rd_dat", r_m0_dat, 32'hCAFEF00D);
        chk("rd_m1_ack", r_m1_ack, 1'b0);
        tick();
        m0_cyc = 0; m0_stb = 0; ack_i = 1;
        #1;
        chk("spurious_gnt", r_gnt, 2'b00);
        chk("spurious_acks", {r_m0_ack, r_m1_ack}, 2'b00);
        tick();
        ack_i = 0;
        #1;
        chk("spurious_state", r_gnt, 2'b00);

        // Round robin with both masters requesting and zero-wait slave.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_idle_gap", r_gnt, 2'b00);
            tick();
            ack_i = 1;
            #1;
            chk("rr_gnt", r_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_acks", {r_m1_ack, r_m0_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            ack_i = 0;
        end

        // Fixed priority: M0 keeps winning until it stops requesting.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_idle_gap", f_gnt, 2'b00);
            tick();
            ack_i = 1;
            #1;
            chk("fp_gnt_m0", f_gnt, 2'b01);
            tick();
            ack_i = 0;
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        ack_i = 1;
        #1;
        chk("fp_gnt_m1", f_gnt, 2'b10);
        chk("fp_m1_ack", f_m1_ack, 1'b1);
        tick();
        ack_i = 0;

        // Timeout on an M1 write; M0 becomes pending during the hung cycle.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h2000; m1_sel = 4'hF;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        #1;
        chk("to_gnt", r_gnt, 2'b10);
        chk("to_adr", r_adr, 32'h2000);
        chk("to_we", r_we, 1'b1);
        for (int c = 2; c <= 7; c++) begin
            tick();
            #1;
            chk("to_no_err", r_m1_err, 1'b0);
            chk("to_cyc_held", r_cyc, 1'b1);
        end
        tick();
        #1;
        chk("to_err", r_m1_err, 1'b1);
        chk("to_cyc_forced", r_cyc, 1'b0);
        chk("to_stb_forced", r_stb, 1'b0);
        chk("to_m0_err", r_m0_err, 1'b0);
        tick();
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #1;
        chk("to_idle", r_gnt, 2'b00);
        chk("to_err_pulse", r_m1_err, 1'b0);
        tick();
        #1;
        chk("to_m0_next", r_gnt, 2'b01);

        // ACK arrives in the same cycle the timeout would fire.
        for (int c = 2; c <= 7; c++) begin
            tick();
            #1;
            chk("ackto_no_err", r_m0_err, 1'b0);
        end
        tick();
        ack_i = 1;
        #1;
        chk("ackto_ack", r_m0_ack, 1'b1);
        chk("ackto_err", r_m0_err, 1'b0);
        chk("ackto_cyc", r_cyc, 1'b1);
        tick();
        ack_i = 0;

        // Asynchronous reset in the middle of an M0 cycle.
        tick();
        #1;
        chk("ar_pre_cyc", r_cyc, 1'b1);
        #1;
        rst_n = 0;
        ack_i = 1;
        #1;
        chk("ar_cyc", r_cyc, 1'b0);
        chk("ar_stb", r_stb, 1'b0);
        chk("ar_gnt", r_gnt, 2'b00);
        chk("ar_acks", {r_m0_ack, r_m1_ack, r_m0_err, r_m1_err}, 4'b0000);
        m0_cyc = 0; m0_stb = 0; ack_i = 0;
        tick();
        rst_n = 1;
        m1_cyc = 1; m1_stb = 1;
        #1;
        chk("ar_release_idle", r_gnt, 2'b00);
        tick();
        #1;
        chk("ar_m1_gnt", r_gnt, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
